// File: rtl/router_fsm.sv
// ----------------------------------------------------------------------------
// router_fsm
//
// Packet-reception controller for the 1x3 router. It sits upstream of the
// three output FIFOs and the input register. It decodes the header address,
// sequences the header, payload and parity loads, and stalls the source
// whenever the selected FIFO is full.
//
// All outputs are Moore decodes of the state register; there are no output
// registers.
//
// Ports
//   clock             in  rising-edge system clock
//   resetn            in  asynchronous active-low reset
//   pkt_valid         in  source is driving header/payload; falls with parity
//   data_in[1:0]      in  header address, sampled in DECODE_ADDRESS
//   fifo_full         in  full flag of the currently selected FIFO
//   fifo_empty_0..2   in  per-FIFO empty flags
//   soft_reset_0..2   in  per-FIFO soft resets (read-side timeout)
//   parity_done       in  register has loaded the parity byte
//   low_packet_valid  in  register saw pkt_valid fall while we were stalled
//   write_enb_reg     out enable a FIFO write this cycle
//   detect_add        out high in DECODE_ADDRESS (synchroniser latches address)
//   ld_state          out high in LOAD_DATA
//   laf_state         out high in LOAD_AFTER_FULL
//   lfd_state         out high in LOAD_FIRST_DATA (header tag)
//   full_state        out high in FIFO_FULL_STATE
//   rst_int_reg       out high in CHECK_PARITY_ERROR
//   busy              out source must hold its data
// ----------------------------------------------------------------------------
module router_fsm #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_packet_valid,
    output logic              write_enb_reg,
    output logic              detect_add,
    output logic              ld_state,
    output logic              laf_state,
    output logic              lfd_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              busy
);

    localparam int ADDR_SPACE = 1 << ADDR_W;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Flags are padded out to the full address space so that the invalid
    // address indexes a defined 0 (never empty, never soft-reset).
    logic [ADDR_SPACE-1:0] emptyVec;
    logic [ADDR_SPACE-1:0] softResetVec;
    logic                  addrValid;
    logic                  headerEmpty;
    logic                  selEmpty;
    logic                  selSoftReset;

    always_comb begin
        emptyVec     = '0;
        softResetVec = '0;
        emptyVec[NUM_PORTS-1:0]     = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        softResetVec[NUM_PORTS-1:0] = {soft_reset_2, soft_reset_1, soft_reset_0};
    end

    assign addrValid    = (32'(data_in) < NUM_PORTS);
    assign headerEmpty  = emptyVec[data_in];
    assign selEmpty     = emptyVec[addr_q];
    assign selSoftReset = softResetVec[addr_q];

    // State and latched address register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state and address-capture logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;

        unique case (state_q)
            DECODE_ADDRESS: begin
                // An invalid header address is simply ignored; we keep
                // waiting for a usable header.
                if (pkt_valid && addrValid) begin
                    addr_d  = data_in;
                    state_d = headerEmpty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (selEmpty) begin
                    state_d = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                state_d = LOAD_DATA;
            end
            LOAD_DATA: begin
                // Full wins over a simultaneous pkt_valid fall; the parity
                // is picked up later via low_packet_valid.
                if (fifo_full) begin
                    state_d = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_d = DECODE_ADDRESS;
                end else if (low_packet_valid) begin
                    state_d = LOAD_PARITY;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                state_d = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: begin
                state_d = DECODE_ADDRESS;
            end
        endcase

        // A soft reset of the selected FIFO abandons the packet in flight.
        if (state_q != DECODE_ADDRESS && selSoftReset) begin
            state_d = DECODE_ADDRESS;
        end
    end

    // Moore output decode.
    always_comb begin
        detect_add    = (state_q == DECODE_ADDRESS);
        ld_state      = (state_q == LOAD_DATA);
        laf_state     = (state_q == LOAD_AFTER_FULL);
        lfd_state     = (state_q == LOAD_FIRST_DATA);
        full_state    = (state_q == FIFO_FULL_STATE);
        rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
        write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                        (state_q == LOAD_AFTER_FULL);
        busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
    end

endmodule

// File: tb/tb_router_fsm.sv
// ----------------------------------------------------------------------------
// tb_router_fsm
//
// Directed testbench for router_fsm. Each scenario task drives stimulus and
// compares the packed output vector against hand-derived per-state values.
// Output vector order:
//   {write_enb_reg, detect_add, ld_state, laf_state,
//    lfd_state, full_state, rst_int_reg, busy}
// ----------------------------------------------------------------------------
module tb_router_fsm;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_packet_valid;
    logic       write_enb_reg, detect_add, ld_state, laf_state;
    logic       lfd_state, full_state, rst_int_reg, busy;
    logic [7:0] obs;

    int checks = 0;
    int errors = 0;

    // Expected output vectors for each state.
    localparam logic [7:0] E_DEC  = 8'b0100_0000;
    localparam logic [7:0] E_WAIT = 8'b0000_0001;
    localparam logic [7:0] E_LFD  = 8'b0000_1001;
    localparam logic [7:0] E_LD   = 8'b1010_0000;
    localparam logic [7:0] E_FULL = 8'b0000_0101;
    localparam logic [7:0] E_LAF  = 8'b1001_0001;
    localparam logic [7:0] E_LP   = 8'b1000_0001;
    localparam logic [7:0] E_CHK  = 8'b0000_0011;

    router_fsm dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .fifo_empty_0     (fifo_empty_0),
        .fifo_empty_1     (fifo_empty_1),
        .fifo_empty_2     (fifo_empty_2),
        .soft_reset_0     (soft_reset_0),
        .soft_reset_1     (soft_reset_1),
        .soft_reset_2     (soft_reset_2),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .write_enb_reg    (write_enb_reg),
        .detect_add       (detect_add),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .lfd_state        (lfd_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .busy             (busy)
    );

    assign obs = {write_enb_reg, detect_add, ld_state, laf_state,
                  lfd_state, full_state, rst_int_reg, busy};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        pkt_valid        = 1'b0;
        data_in          = 2'b00;
        fifo_full        = 1'b0;
        fifo_empty_0     = 1'b1;
        fifo_empty_1     = 1'b1;
        fifo_empty_2     = 1'b1;
        soft_reset_0     = 1'b0;
        soft_reset_1     = 1'b0;
        soft_reset_2     = 1'b0;
        parity_done      = 1'b0;
        low_packet_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (obs !== E_DEC) begin
            errors++;
            $display("[TB] FAIL reset_initial: got %b expected %b", obs, E_DEC);
        end
        tick();
        resetn = 1'b1;
        // Drive into LOAD_DATA, then assert reset mid-cycle.
        pkt_valid = 1'b1;
        data_in   = 2'b01;
        tick();
        tick();
        checks++;
        if (obs !== E_LD) begin
            errors++;
            $display("[TB] FAIL reset_reach_ld: got %b expected %b", obs, E_LD);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (obs !== E_DEC) begin
            errors++;
            $display("[TB] FAIL reset_async: got %b expected %b", obs, E_DEC);
        end
        tick();
        resetn    = 1'b1;
        pkt_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== E_DEC) begin
                errors++;
                $display("[TB] FAIL reset_hold[%0d]: got %b expected %b", i, obs, E_DEC);
            end
        end
    endtask

    task automatic test_normal();
        idle_inputs();
        pkt_valid = 1'b1;
        data_in   = 2'b01;
        tick();
        checks++;
        if (obs !== E_LFD) begin
            errors++;
            $display("[TB] FAIL normal_lfd: got %b expected %b", obs, E_LFD);
        end
        data_in = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== E_LD) begin
                errors++;
                $display("[TB] FAIL normal_ld[%0d]: got %b expected %b", i, obs, E_LD);
            end
        end
        pkt_valid = 1'b0;
        tick();
        checks++;
        if (obs !== E_LP) begin
            errors++;
            $display("[TB] FAIL normal_lp: got %b expected %b", obs, E_LP);
        end
        tick();
        checks++;
        if (obs !== E_CHK) begin
            errors++;
            $display("[TB] FAIL normal_chk: got %b expected %b", obs, E_CHK);
        end
        tick();
        checks++;
        if (obs !== E_DEC) begin
            errors++;
            $display("[TB] FAIL normal_dec: got %b expected %b", obs, E_DEC);
        end
    endtask

    task automatic test_wait();
        idle_inputs();
        fifo_empty_2 = 1'b0;
        pkt_valid    = 1'b1;
        data_in      = 2'b10;
        tick();
        // Header input now points at an empty port; only the latched port matters.
        data_in = 2'b00;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== E_WAIT) begin
                errors++;
                $display("[TB] FAIL wait_hold[%0d]: got %b expected %b", i, obs, E_WAIT);
            end
            if (i < 4) tick();
        end
        fifo_empty_2 = 1'b1;
        tick();
        checks++;
        if (obs !== E_LFD) begin
            errors++;
            $display("[TB] FAIL wait_lfd: got %b expected %b", obs, E_LFD);
        end
        pkt_valid = 1'b0;
        tick();
        checks++;
        if (obs !== E_LD) begin
            errors++;
            $display("[TB] FAIL wait_ld: got %b expected %b", obs, E_LD);
        end
        tick();
        tick();
        tick();
        checks++;
        if (obs !== E_DEC) begin
            errors++;
            $display("[TB] FAIL wait_dec: got %b expected %b", obs, E_DEC);
        end
    endtask

    task automatic test_full();
        idle_inputs();
        pkt_valid = 1'b1;
        data_in   = 2'b00;
        tick();
        tick();
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== E_FULL) begin
                errors++;
                $display("[TB] FAIL full_hold[%0d]: got %b expected %b", i, obs, E_FULL);
            end
        end
        fifo_full        = 1'b0;
        pkt_valid        = 1'b0;
        low_packet_valid = 1'b1;
        tick();
        checks++;
        if (obs !== E_LAF) begin
            errors++;
            $display("[TB] FAIL full_laf: got %b expected %b", obs, E_LAF);
        end
        tick();
        checks++;
        if (obs !== E_LP) begin
            errors++;
            $display("[TB] FAIL full_laf_to_lp: got %b expected %b", obs, E_LP);
        end
        low_packet_valid = 1'b0;
        tick();
        // Full seen in CHECK_PARITY_ERROR goes back to the full stall.
        fifo_full = 1'b1;
        tick();
        checks++;
        if (obs !== E_FULL) begin
            errors++;
            $display("[TB] FAIL full_chk_to_full: got %b expected %b", obs, E_FULL);
        end
        fifo_full = 1'b0;
        tick();
        // LAF with neither parity_done nor low_packet_valid resumes payload.
        tick();
        checks++;
        if (obs !== E_LD) begin
            errors++;
            $display("[TB] FAIL full_laf_to_ld: got %b expected %b", obs, E_LD);
        end
        // Simultaneous full and pkt_valid fall: full takes priority.
        fifo_full = 1'b1;
        pkt_valid = 1'b0;
        tick();
        checks++;
        if (obs !== E_FULL) begin
            errors++;
            $display("[TB] FAIL full_priority: got %b expected %b", obs, E_FULL);
        end
        fifo_full = 1'b0;
        tick();
        parity_done = 1'b1;
        tick();
        checks++;
        if (obs !== E_DEC) begin
            errors++;
            $display("[TB] FAIL full_laf_parity_done: got %b expected %b", obs, E_DEC);
        end
        parity_done = 1'b0;
    endtask

    task automatic test_soft_reset();
        idle_inputs();
        pkt_valid = 1'b1;
        data_in   = 2'b00;
        tick();
        tick();
        soft_reset_1 = 1'b1;
        tick();
        checks++;
        if (obs !== E_LD) begin
            errors++;
            $display("[TB] FAIL soft_other_port: got %b expected %b", obs, E_LD);
        end
        soft_reset_1 = 1'b0;
        soft_reset_0 = 1'b1;
        tick();
        checks++;
        if (obs !== E_DEC) begin
            errors++;
            $display("[TB] FAIL soft_own_port: got %b expected %b", obs, E_DEC);
        end
        soft_reset_0 = 1'b0;
        pkt_valid    = 1'b0;
        tick();
    endtask

    task automatic test_invalid_addr();
        idle_inputs();
        pkt_valid = 1'b1;
        data_in   = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== E_DEC) begin
                errors++;
                $display("[TB] FAIL invalid_addr[%0d]: got %b expected %b", i, obs, E_DEC);
            end
        end
        pkt_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_wait();
        test_full();
        test_soft_reset();
        test_invalid_addr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
